// File: rtl/paint_pkg.sv
// rtl/paint_pkg.sv - canvas geometry, widths and controller state encoding
package paint_pkg;
    localparam int CANVAS_W    = 160;
    localparam int CANVAS_H    = 120;
    localparam int CANVAS_SIZE = CANVAS_W * CANVAS_H;
    localparam int ADDR_W      = 15;
    localparam int COLOUR_W    = 12;
    // internal arithmetic width, wide enough that y-1 / x-1 wrap far off-canvas
    localparam int CALC_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_STAMP   = 2'd2,
        ST_CLEAR   = 2'd3
    } state_e;
endpackage

// File: rtl/canvas_write_ctrl_if.sv
// rtl/canvas_write_ctrl_if.sv - framebuffer write bus with ready backpressure
interface canvas_write_ctrl_if import paint_pkg::*; #(
    parameter int COLOUR_W = 12
);
    logic                fb_we;
    logic [ADDR_W-1:0]   fb_addr;
    logic [COLOUR_W-1:0] fb_data;
    logic                fb_ready;

    modport master (output fb_we, output fb_addr, output fb_data, input fb_ready);
    modport slave  (input fb_we, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/addr_to_xy.sv
// rtl/addr_to_xy.sv - iterative linear address to (x,y) divider, one row per cycle
module addr_to_xy import paint_pkg::*; #(
    parameter int WIDTH = 160
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CALC_W-1:0] addr,
    output logic              done,
    output logic [CALC_W-1:0] x,
    output logic [CALC_W-1:0] y
);
    localparam logic [CALC_W-1:0] W_C = CALC_W'(WIDTH);

    logic              running;
    logic [CALC_W-1:0] rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            rem     <= '0;
            y       <= '0;
        end else if (start) begin
            running <= 1'b1;
            rem     <= addr;
            y       <= '0;
        end else if (running) begin
            if (rem >= W_C) begin
                rem <= rem - W_C;
                y   <= y + CALC_W'(1);
            end else begin
                running <= 1'b0;
            end
        end
    end

    // done is combinational so the caller leaves CONVERT on the same edge the remainder settles
    assign done = running && (rem < W_C);
    assign x    = rem;
endmodule

// File: rtl/canvas_write_ctrl.sv
// rtl/canvas_write_ctrl.sv - paint stamp and full-canvas clear write sequencer
module canvas_write_ctrl import paint_pkg::*; #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int COLOUR_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 paint_req,
    input  logic [ADDR_W-1:0]    paint_pixel,
    input  logic [COLOUR_W-1:0]  paint_colour,
    input  logic                 brush_big,
    input  logic                 clear_req,
    input  logic [COLOUR_W-1:0]  clear_colour,
    canvas_write_ctrl_if.master  fb,
    output logic                 busy,
    output logic                 clear_done
);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_CONVERT = ST_CONVERT;
    localparam logic [1:0] S_STAMP   = ST_STAMP;
    localparam logic [1:0] S_CLEAR   = ST_CLEAR;

    localparam logic [CALC_W-1:0] W_C    = CALC_W'(WIDTH);
    localparam logic [CALC_W-1:0] H_C    = CALC_W'(HEIGHT);
    localparam logic [CALC_W-1:0] SIZE_C = CALC_W'(WIDTH * HEIGHT);

    logic [1:0]          state;
    logic [CALC_W-1:0]   lat_pixel;
    logic [COLOUR_W-1:0] lat_colour;
    logic                lat_big;
    logic                match_valid;
    logic [CALC_W-1:0]   x_r;
    logic [CALC_W-1:0]   y_r;
    logic [1:0]          dy_i;
    logic [1:0]          dx_i;
    logic [CALC_W-1:0]   clr_addr;
    logic [COLOUR_W-1:0] clr_colour_r;
    logic                clr_pend;
    logic [COLOUR_W-1:0] pend_colour;

    logic [CALC_W-1:0]   pix_ext;
    logic                paint_ok;
    logic                div_start;
    logic                div_done;
    logic [CALC_W-1:0]   div_x;
    logic [CALC_W-1:0]   div_y;
    logic [CALC_W-1:0]   xx;
    logic [CALC_W-1:0]   yy;
    logic [CALC_W-1:0]   stamp_addr;
    logic                on_canvas;
    logic                stamp_last;
    logic                stamp_adv;

    assign pix_ext  = {{(CALC_W-ADDR_W){1'b0}}, paint_pixel};
    assign paint_ok = paint_req && (pix_ext < SIZE_C) &&
                      !(match_valid && pix_ext == lat_pixel &&
                        paint_colour == lat_colour && brush_big == lat_big);
    assign div_start = (state == S_IDLE) && !clear_req && !clr_pend && paint_ok;

    addr_to_xy #(.WIDTH(WIDTH)) u_addr_to_xy (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .addr  (pix_ext),
        .done  (div_done),
        .x     (div_x),
        .y     (div_y)
    );

    // offsets are stored biased by +1; x-1 / y-1 at the edge wraps to a huge unsigned value
    assign xx         = x_r + CALC_W'(dx_i) - CALC_W'(1);
    assign yy         = y_r + CALC_W'(dy_i) - CALC_W'(1);
    assign on_canvas  = (xx < W_C) && (yy < H_C);
    assign stamp_addr = yy * W_C + xx;
    assign stamp_last = !lat_big || (dy_i == 2'd2 && dx_i == 2'd2);
    assign stamp_adv  = !on_canvas || fb.fb_ready;

    assign busy = (state != S_IDLE);

    always_comb begin
        fb.fb_we   = 1'b0;
        fb.fb_addr = '0;
        fb.fb_data = '0;
        case (state)
            S_STAMP: begin
                fb.fb_we   = on_canvas;
                fb.fb_addr = on_canvas ? stamp_addr[ADDR_W-1:0] : '0;
                fb.fb_data = lat_colour;
            end
            S_CLEAR: begin
                fb.fb_we   = 1'b1;
                fb.fb_addr = clr_addr[ADDR_W-1:0];
                fb.fb_data = clr_colour_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            lat_pixel    <= '0;
            lat_colour   <= '0;
            lat_big      <= 1'b0;
            match_valid  <= 1'b0;
            x_r          <= '0;
            y_r          <= '0;
            dy_i         <= 2'd0;
            dx_i         <= 2'd0;
            clr_addr     <= '0;
            clr_colour_r <= '0;
            clr_pend     <= 1'b0;
            pend_colour  <= '0;
            clear_done   <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            if (!paint_req) match_valid <= 1'b0;
            // a clear arriving mid-paint waits; the first requester's colour is kept
            if ((state == S_CONVERT || state == S_STAMP) && clear_req && !clr_pend) begin
                clr_pend    <= 1'b1;
                pend_colour <= clear_colour;
            end
            case (state)
                S_IDLE: begin
                    if (clear_req || clr_pend) begin
                        state        <= S_CLEAR;
                        clr_colour_r <= clear_req ? clear_colour : pend_colour;
                        clr_pend     <= 1'b0;
                        clr_addr     <= '0;
                    end else if (paint_ok) begin
                        lat_pixel  <= pix_ext;
                        lat_colour <= paint_colour;
                        lat_big    <= brush_big;
                        state      <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (div_done) begin
                        x_r   <= div_x;
                        y_r   <= div_y;
                        dy_i  <= lat_big ? 2'd0 : 2'd1;
                        dx_i  <= lat_big ? 2'd0 : 2'd1;
                        state <= S_STAMP;
                    end
                end
                S_STAMP: begin
                    if (stamp_adv) begin
                        if (stamp_last) begin
                            state       <= S_IDLE;
                            match_valid <= 1'b1;
                        end else if (dx_i == 2'd2) begin
                            dx_i <= 2'd0;
                            dy_i <= dy_i + 2'd1;
                        end else begin
                            dx_i <= dx_i + 2'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (fb.fb_ready) begin
                        if (clr_addr == SIZE_C - CALC_W'(1)) begin
                            state       <= S_IDLE;
                            clr_addr    <= '0;
                            clear_done  <= 1'b1;
                            match_valid <= 1'b0;
                        end else begin
                            clr_addr <= clr_addr + CALC_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_canvas_write_ctrl.sv
// tb/tb_canvas_write_ctrl.sv - scoreboard bench for canvas_write_ctrl
module tb_canvas_write_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        paint_req = 1'b0;
    logic [14:0] paint_pixel = '0;
    logic [11:0] paint_colour = '0;
    logic        brush_big = 1'b0;
    logic        clear_req = 1'b0;
    logic [11:0] clear_colour = '0;
    logic        busy;
    logic        clear_done;
    logic        rand_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int n_wr = 0;
    int n_nowe = 0;
    int n_done = 0;
    int exp_addr[$];
    int exp_data[$];

    canvas_write_ctrl_if #(.COLOUR_W(12)) fb();

    canvas_write_ctrl #(.WIDTH(160), .HEIGHT(120), .COLOUR_W(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .paint_req    (paint_req),
        .paint_pixel  (paint_pixel),
        .paint_colour (paint_colour),
        .brush_big    (brush_big),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .fb           (fb),
        .busy         (busy),
        .clear_done   (clear_done)
    );

    always #5 clk = ~clk;

    always begin
        fb.fb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            fb.fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic push(input int a, input int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    always @(negedge clk) begin
        if (busy && !fb.fb_we) n_nowe++;
        if (clear_done) n_done++;
        if (fb.fb_we && fb.fb_ready) begin
            n_wr++;
            if (exp_addr.size() == 0) begin
                chk("extra_wr_addr", int'(fb.fb_addr), -1);
            end else begin
                chk("wr_addr", int'(fb.fb_addr), exp_addr.pop_front());
                chk("wr_data", int'(fb.fb_data), exp_data.pop_front());
            end
        end else if (fb.fb_we && exp_addr.size() > 0) begin
            chk("stall_addr", int'(fb.fb_addr), exp_addr[0]);
            chk("stall_data", int'(fb.fb_data), exp_data[0]);
        end
    end

    task automatic do_paint(input int pix, input int col, input bit big, input int hold, input int exp_lat);
        int lat;
        lat = 0;
        @(posedge clk);
        #1;
        paint_pixel  = 15'(pix);
        paint_colour = 12'(col);
        brush_big    = big;
        paint_req    = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (lat == 0 && fb.fb_we) lat = i;
            @(posedge clk);
            #1;
            if (i >= hold) paint_req = 1'b0;
            if (lat != 0 && i >= hold) break;
        end
        paint_req = 1'b0;
        chk("latency", lat, exp_lat);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic pulse_clear(input int col);
        @(posedge clk);
        #1;
        clear_colour = 12'(col);
        clear_req    = 1'b1;
        @(posedge clk);
        #1;
        clear_req    = 1'b0;
    endtask

    initial begin
        int w0, s0, d0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", int'(fb.fb_we), 0);
        chk("rst_addr", int'(fb.fb_addr), 0);
        chk("rst_data", int'(fb.fb_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(clear_done), 0);
        reset = 1'b1;

        // single pixel, request held: dedup must allow exactly one write
        w0 = n_wr;
        push(100, 'hF00);
        do_paint(100, 'hF00, 1'b0, 20, 3);
        wait_idle(50);
        chk("dedup_writes", n_wr - w0, 1);
        chk("sb_left_single", exp_addr.size(), 0);

        // top-left corner 3x3
        s0 = n_nowe;
        push(0, 'hABC); push(1, 'hABC); push(160, 'hABC); push(161, 'hABC);
        do_paint(0, 'hABC, 1'b1, 1, 7);
        wait_idle(50);
        chk("corner_tl_nowe", n_nowe - s0, 6);
        chk("sb_left_tl", exp_addr.size(), 0);

        // bottom-right corner 3x3
        s0 = n_nowe;
        push(19038, 'h5A5); push(19039, 'h5A5); push(19198, 'h5A5); push(19199, 'h5A5);
        do_paint(19199, 'h5A5, 1'b1, 1, 122);
        wait_idle(50);
        chk("corner_br_nowe", n_nowe - s0, 125);
        chk("sb_left_br", exp_addr.size(), 0);

        // out-of-range pixel ignored
        w0 = n_wr;
        @(posedge clk); #1;
        paint_pixel = 15'd19200; paint_req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("oor_busy", int'(busy), 0);
        paint_req = 1'b0;
        chk("oor_writes", n_wr - w0, 0);

        // full clear with random backpressure
        d0 = n_done;
        for (int a = 0; a < 19200; a++) push(a, 'h0F0);
        rand_ready = 1'b1;
        pulse_clear('h0F0);
        wait_idle(60000);
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("clear_done_cnt", n_done - d0, 1);
        chk("clear_addr_idle", int'(fb.fb_addr), 0);
        chk("sb_left_clear", exp_addr.size(), 0);

        // clear requested mid-stamp, paint during clear ignored
        d0 = n_done;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                push((3 + dy) * 160 + 20 + dx, 'h123);
        for (int a = 0; a < 19200; a++) push(a, 'h456);
        do_paint(500, 'h123, 1'b1, 1, 6);
        pulse_clear('h456);
        repeat (20) @(posedge clk);
        #1;
        chk("busy_in_clear", int'(busy), 1);
        paint_pixel = 15'd7; paint_colour = 12'h001; brush_big = 1'b0; paint_req = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        paint_req = 1'b0;
        wait_idle(30000);
        repeat (2) @(negedge clk);
        chk("pend_done_cnt", n_done - d0, 1);
        chk("sb_left_pend", exp_addr.size(), 0);

        // asynchronous reset mid-clear, then a normal paint
        for (int a = 0; a < 19200; a++) push(a, 'h0F0);
        pulse_clear('h0F0);
        repeat (100) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_we", int'(fb.fb_we), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_addr", int'(fb.fb_addr), 0);
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        w0 = n_wr;
        push(321, 'h777);
        do_paint(321, 'h777, 1'b0, 1, 5);
        wait_idle(50);
        chk("post_rst_writes", n_wr - w0, 1);
        chk("sb_left_post", exp_addr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
